// File: rtl/sdm_mash_nw_if.sv
// rtl/sdm_mash_nw_if.sv - control and divide-output bundle for sdm_mash_nw
interface sdm_mash_nw_if #(
  parameter int W  = 16,
  parameter int NW = 6
);
  logic          en;
  logic          ld;
  logic [W-1:0]  frac_in;
  logic [NW-1:0] n_in;
  logic [1:0]    order_in;
  logic          dith_en;
  logic [NW:0]   div_out;
  logic [W-1:0]  qn;
  logic          sat;
  logic          busy;

  modport master (
    output en, ld, frac_in, n_in, order_in, dith_en,
    input  div_out, qn, sat, busy
  );

  modport slave (
    input  en, ld, frac_in, n_in, order_in, dith_en,
    output div_out, qn, sat, busy
  );
endinterface

// File: rtl/sdm_mash_nw.sv
// rtl/sdm_mash_nw.sv - MASH 1-1-1 sigma-delta modulator with run-time order, dither and clamp
module sdm_mash_nw #(
  parameter int          W    = 16,
  parameter int          NW   = 6,
  parameter logic [14:0] SEED = 15'h0001
) (
  input  logic         clk,
  input  logic         rst,
  sdm_mash_nw_if.slave bus
);

  logic [W-1:0]  frac_a;
  logic [NW-1:0] n_a;
  logic [1:0]    ord_a;

  logic [W-1:0]  acc1, acc2, acc3;
  logic          c1, c2, c3;
  logic          c2d, c3d1, c3d2;
  logic [14:0]   lfsr;

  logic [NW:0]   div_q;
  logic          sat_q;
  logic          busy_q;

  logic [1:0]    ord_new;
  logic          clr;
  logic          dith_bit;
  logic [W:0]    s1, s2, s3;
  logic [3:0]    y1, y2, y3, y;
  logic [NW+1:0] t;

  // Order 0 is folded to 1 before comparing, so loading 0 over 1 is not a change.
  always_comb begin
    ord_new  = (bus.order_in == 2'd0) ? 2'd1 : bus.order_in;
    clr      = bus.ld && (ord_new != ord_a);
    dith_bit = bus.dith_en & lfsr[0];

    s1 = {1'b0, acc1} + {1'b0, frac_a} + {{W{1'b0}}, dith_bit};
    s2 = {1'b0, acc2} + {1'b0, s1[W-1:0]};
    s3 = {1'b0, acc3} + {1'b0, s2[W-1:0]};
  end

  // Noise-shaping combiner in 4-bit two's complement; range -3..4 fits.
  always_comb begin
    y1 = {3'b000, c1};
    y2 = {3'b000, c2} - {3'b000, c2d};
    y3 = {3'b000, c3} - {2'b00, c3d1, 1'b0} + {3'b000, c3d2};
    case (ord_a)
      2'd3:    y = y1 + y2 + y3;
      2'd2:    y = y1 + y2;
      default: y = y1;
    endcase
    t = {2'b00, n_a} + {{(NW-2){y[3]}}, y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_a <= '0;
      n_a    <= '0;
      ord_a  <= 2'd1;
    end else if (bus.ld) begin
      frac_a <= bus.frac_in;
      n_a    <= bus.n_in;
      ord_a  <= ord_new;
    end
  end

  // An order change wipes the whole noise state; it wins over a step on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc1 <= '0;
      acc2 <= '0;
      acc3 <= '0;
      c1   <= 1'b0;
      c2   <= 1'b0;
      c3   <= 1'b0;
      c2d  <= 1'b0;
      c3d1 <= 1'b0;
      c3d2 <= 1'b0;
      lfsr <= SEED;
    end else if (clr) begin
      acc1 <= '0;
      acc2 <= '0;
      acc3 <= '0;
      c1   <= 1'b0;
      c2   <= 1'b0;
      c3   <= 1'b0;
      c2d  <= 1'b0;
      c3d1 <= 1'b0;
      c3d2 <= 1'b0;
    end else if (bus.en) begin
      acc1 <= s1[W-1:0];
      c1   <= s1[W];
      acc2 <= (ord_a >= 2'd2) ? s2[W-1:0] : '0;
      c2   <= (ord_a >= 2'd2) & s2[W];
      acc3 <= (ord_a == 2'd3) ? s3[W-1:0] : '0;
      c3   <= (ord_a == 2'd3) & s3[W];
      c2d  <= c2;
      c3d1 <= c3;
      c3d2 <= c3d1;
      if (bus.dith_en) begin
        lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= clr;
      if (bus.en) begin
        if (clr) begin
          div_q <= {1'b0, bus.n_in};
          sat_q <= 1'b0;
        end else if (t[NW+1]) begin
          div_q <= '0;
          sat_q <= 1'b1;
        end else begin
          div_q <= t[NW:0];
          sat_q <= 1'b0;
        end
      end
    end
  end

  assign bus.div_out = div_q;
  assign bus.sat     = sat_q;
  assign bus.busy    = busy_q;
  assign bus.qn      = acc1;

endmodule

// File: tb/tb_sdm_mash_nw.sv
// tb/tb_sdm_mash_nw.sv - self-checking bench for sdm_mash_nw
module tb_sdm_mash_nw;
  localparam int W  = 16;
  localparam int NW = 6;

  typedef struct {
    int div;
    int qn;
    bit sat;
    bit busy;
  } exp_t;

  typedef struct {
    bit en;
    bit ld;
    int frac;
    int n;
    int ord;
    bit dith;
    int div;
    int qn;
    bit sat;
    bit busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_step = 0;

  exp_t sb_q[$];
  vec_t tbl[$];

  int m_acc1, m_acc2, m_acc3;
  int m_c1, m_c2, m_c3, m_c2d, m_c3d1, m_c3d2;
  int m_frac, m_n, m_ord, m_lfsr;
  int m_div;
  bit m_sat, m_busy;

  sdm_mash_nw_if #(.W(W), .NW(NW)) bus ();

  sdm_mash_nw #(.W(W), .NW(NW), .SEED(15'h0001)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, step %0d", n_step);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
    m_c1 = 0; m_c2 = 0; m_c3 = 0; m_c2d = 0; m_c3d1 = 0; m_c3d2 = 0;
    m_frac = 0; m_n = 0; m_ord = 1; m_lfsr = 1;
    m_div = 0; m_sat = 0; m_busy = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input int frac, input int n,
                            input int ord, input bit dith);
    int ordn, y, t, a1, a2, a3, fb;
    bit clr;
    ordn = (ord == 0) ? 1 : ord;
    clr  = ld && (ordn != m_ord);
    y = m_c1;
    if (m_ord >= 2) y = y + m_c2 - m_c2d;
    if (m_ord == 3) y = y + m_c3 - 2 * m_c3d1 + m_c3d2;
    m_busy = clr;
    if (en) begin
      if (clr) begin
        m_div = n; m_sat = 0;
      end else begin
        t = m_n + y;
        if (t < 0) begin m_div = 0; m_sat = 1; end
        else begin m_div = t; m_sat = 0; end
      end
    end
    if (clr) begin
      m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
      m_c1 = 0; m_c2 = 0; m_c3 = 0; m_c2d = 0; m_c3d1 = 0; m_c3d2 = 0;
    end else if (en) begin
      a1 = m_acc1 + m_frac + (dith ? (m_lfsr & 1) : 0);
      a2 = m_acc2 + (a1 % 65536);
      a3 = m_acc3 + (a2 % 65536);
      m_c3d2 = m_c3d1; m_c3d1 = m_c3; m_c2d = m_c2;
      m_acc1 = a1 % 65536; m_c1 = a1 / 65536;
      if (m_ord >= 2) begin m_acc2 = a2 % 65536; m_c2 = a2 / 65536; end
      else begin m_acc2 = 0; m_c2 = 0; end
      if (m_ord == 3) begin m_acc3 = a3 % 65536; m_c3 = a3 / 65536; end
      else begin m_acc3 = 0; m_c3 = 0; end
      if (dith) begin
        fb = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 32'h7fff;
      end
    end
    if (ld) begin m_frac = frac; m_n = n; m_ord = ordn; end
  endtask

  task automatic step(input bit en, input bit ld, input int frac, input int n,
                      input int ord, input bit dith);
    exp_t e;
    bus.en = en; bus.ld = ld; bus.frac_in = frac[W-1:0]; bus.n_in = n[NW-1:0];
    bus.order_in = ord[1:0]; bus.dith_en = dith;
    model_step(en, ld, frac, n, ord, dith);
    e.div = m_div; e.qn = m_qn_val(); e.sat = m_sat; e.busy = m_busy;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_step++;
    n_vec++;
    if ($isunknown({bus.div_out, bus.qn, bus.sat, bus.busy}) ||
        int'(bus.div_out) != e.div || int'(bus.qn) != e.qn ||
        bus.sat != e.sat || bus.busy != e.busy) begin
      n_err++;
      $display("FAIL model step%0d: div_out=%0d qn=%0d sat=%0b busy=%0b, want div_out=%0d qn=%0d sat=%0b busy=%0b",
               n_step, bus.div_out, bus.qn, bus.sat, bus.busy, e.div, e.qn, e.sat, e.busy);
    end
  endtask

  function automatic int m_qn_val();
    return m_acc1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int sum, y, bad, varied;
    tbl.push_back('{1, 1,     0, 31, 3, 0, 31,     0, 0, 1});
    tbl.push_back('{1, 0,     0, 31, 3, 0, 31,     0, 0, 0});
    tbl.push_back('{1, 0,     0, 31, 3, 0, 31,     0, 0, 0});
    tbl.push_back('{1, 1, 32768, 31, 1, 0, 31,     0, 0, 1});
    tbl.push_back('{1, 0, 32768, 31, 1, 0, 31, 32768, 0, 0});
    tbl.push_back('{1, 0, 32768, 31, 1, 0, 31,     0, 0, 0});
    tbl.push_back('{1, 0, 32768, 31, 1, 0, 32, 32768, 0, 0});
    tbl.push_back('{1, 0, 32768, 31, 1, 0, 31,     0, 0, 0});
    tbl.push_back('{1, 0, 32768, 31, 1, 0, 32, 32768, 0, 0});
    tbl.push_back('{1, 1, 32768, 40, 1, 0, 31,     0, 0, 0});
    tbl.push_back('{1, 0, 32768, 40, 1, 0, 41, 32768, 0, 0});
    tbl.push_back('{0, 0, 32768, 40, 1, 0, 41, 32768, 0, 0});
    tbl.push_back('{0, 1, 32768, 20, 1, 0, 41, 32768, 0, 0});
    tbl.push_back('{1, 0, 32768, 20, 1, 0, 20,     0, 0, 0});
    tbl.push_back('{1, 0, 32768, 20, 1, 0, 21, 32768, 0, 0});
    tbl.push_back('{1, 1, 32768, 20, 0, 0, 20,     0, 0, 0});
    tbl.push_back('{1, 0, 32768, 20, 1, 0, 21, 32768, 0, 0});

    bus.en = 0; bus.ld = 0; bus.frac_in = '0; bus.n_in = '0; bus.order_in = 2'd1; bus.dith_en = 0;
    model_reset();
    #3;
    chk("rst_div", int'(bus.div_out), 0);
    chk("rst_qn", int'(bus.qn), 0);
    chk("rst_sat", int'(bus.sat), 0);
    chk("rst_busy", int'(bus.busy), 0);
    #9 rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].ld, tbl[i].frac, tbl[i].n, tbl[i].ord, tbl[i].dith);
      chk($sformatf("tbl%0d_div", i), int'(bus.div_out), tbl[i].div);
      chk($sformatf("tbl%0d_qn", i), int'(bus.qn), tbl[i].qn);
      chk($sformatf("tbl%0d_sat", i), int'(bus.sat), int'(tbl[i].sat));
      chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
    end

    // Mid-run order change 3 -> 2, then a hold window with a load inside it
    step(1, 1, 26625, 31, 3, 0);
    for (int i = 0; i < 60; i++) step(1, 0, 26625, 31, 3, 0);
    step(1, 1, 26625, 31, 2, 0);
    chk("ordchg_busy", int'(bus.busy), 1);
    chk("ordchg_qn", int'(bus.qn), 0);
    chk("ordchg_div", int'(bus.div_out), 31);
    step(1, 0, 26625, 31, 2, 0);
    chk("ordchg_busy_drop", int'(bus.busy), 0);
    for (int i = 0; i < 30; i++) step(1, 0, 26625, 31, 2, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 26625, 31, 2, 0);
    step(0, 1, 26625, 45, 2, 0);
    step(1, 0, 26625, 45, 2, 0);

    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1, 0, 26625, 45, 2, 0);
      y = int'(bus.div_out) - 45;
      if (y < -1 || y > 2) bad++;
    end
    chk("ord2_range_violations", bad, 0);

    // Clamp region: n=1 with third-order noise
    step(1, 1, 26625, 1, 3, 0);
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1, 0, 26625, 1, 3, 0);
      if (int'(bus.div_out) > 5) bad++;
      if (bus.sat && bus.div_out != 0) bad++;
    end
    chk("clamp_violations", bad, 0);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_div", int'(bus.div_out), 0);
    chk("arst_qn", int'(bus.qn), 0);
    chk("arst_sat", int'(bus.sat), 0);
    chk("arst_busy", int'(bus.busy), 0);
    model_reset();
    #3 rst = 1'b0;
    step(1, 0, 9999, 50, 3, 0);
    chk("post_rst_div", int'(bus.div_out), 0);

    // Dither with zero fraction, third order so carries appear quickly
    step(1, 1, 0, 31, 3, 1);
    varied = 0;
    for (int i = 0; i < 600; i++) begin
      step(1, 0, 0, 31, 3, 1);
      if (bus.div_out != 31) varied = 1;
    end
    chk("dither_varies", varied, 1);

    // Long-run mean for order 3
    step(1, 1, 26625, 31, 3, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 26625, 31, 3, 0);
    sum = 0;
    bad = 0;
    for (int i = 0; i < 65536; i++) begin
      step(1, 0, 26625, 31, 3, 0);
      y = int'(bus.div_out) - 31;
      sum += y;
      if (y < -3 || y > 4) bad++;
    end
    chk("ord3_range_violations", bad, 0);
    n_vec++;
    if (sum < 26622 || sum > 26628) begin
      n_err++;
      $display("FAIL mean_sum: got %0d want 26625 +/- 3", sum);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sdm_mash_nw.md
# sdm_mash_nw

Parametrised MASH 1-1-1 sigma-delta modulator for the fractional-N divider path. It is the next generation of the fixed third-order `sdm`. New features:

- run-time order select (1/2/3);
- parametrised fraction and integer widths;
- optional LFSR LSB dither;
- glitch-free configuration loading;
- output clamping with a saturation flag.

It sits between the channel/frequency control registers and the multi-modulus divider. It issues one divide value per reference clock.

## Interface
Parameters:
- W, 16, fraction/accumulator width
- NW, 6, integer divide width
- SEED, 15'h0001, dither LFSR reset seed (must be nonzero)

Ports:
- clk  in  1  reference clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  1  modulator step enable
- ld  in  1  configuration load strobe
- frac_in  in  W  fractional word, unsigned
- n_in  in  NW  integer divide, unsigned
- order_in  in  2  1, 2 or 3; values 0 and 3'd… 0 is treated as 1
- dith_en  in  1  enable LSB dither on stage-1 input
- div_out  out  NW+1  divide control N+y, unsigned, clamped
- qn  out  W  stage-1 accumulator residue (acc1)
- sat  out  1  div_out clamped this cycle
- busy  out  1  high for the cycle in which an order change clears state

## Operation
- **Active configuration registers** frac_a, n_a, ord_a:
  - Loaded on posedge when ld=1, independent of en.
  - Reset values: 0, 0, 1.
- **Order change:**
  - If ld=1 and order_in differs from ord_a, the same edge clears acc1..3, all carry registers and all delay registers, and sets busy=1 for one cycle.
  - frac_a- or n_a-only loads do not clear state.
- **Step** (posedge, en=1, no clear):
  - s1 = acc1 + frac_a + d, computed in W+1 bits, where d = dith_en & lfsr[0].
  - acc1 <= s1[W-1:0]; c1 <= s1[W].
  - s2 = acc2 + s1[W-1:0]; acc2 <= low W bits; c2 <= carry.
  - s3 = acc3 + s2[W-1:0]; acc3 <= low W bits; c3 <= carry.
  - Delay registers: c2d <= c2; c3d1 <= c3; c3d2 <= c3d1.
  - Stages beyond ord_a are held at 0 (accumulator and carry).
- **Combiner** (signed, combinational on registered carries):
  - y1 = c1; y2 = c2 - c2d; y3 = c3 - 2*c3d1 + c3d2.
  - order 1: y = y1, range 0..1.
  - order 2: y = y1+y2, range -1..2.
  - order 3: y = y1+y2+y3, range -3..4.
- **Output register** (posedge, en=1):
  - t = n_a + y, computed as signed NW+2 bits.
  - If t < 0: div_out <= 0, sat <= 1.
  - Otherwise: div_out <= t[NW:0], sat <= 0.
- **LFSR:** 15-bit Fibonacci, x^15+x^14+1. It advances only on en=1 steps while dith_en=1, and resets to SEED.
- **qn** = acc1, driven directly.
- **en=0:** all accumulators, carries, delays, LFSR, div_out and sat hold. ld still works.

## Timing
- **Reset values:**
  - div_out = 0, qn = 0, sat = 0, busy = 0.
  - All accumulators, carries and delay registers = 0.
  - LFSR = SEED.
- **Latency:**
  - A frac_a loaded at edge k is first used in the accumulator update at the next enabled edge k+1.
  - Its carry reaches div_out at enabled edge k+2.
  - An n_a change alone appears in div_out at the first enabled edge after the ld edge.
- **Simultaneous ld and en** on an order change: the clear has priority and the accumulators do not step that edge. div_out <= n_a_new + 0 on that edge.
- **ld held high:** reloads every edge. A constant order_in causes no repeated clears.
- **Reset asserted mid-operation:** all state returns to reset values immediately, with no clk edge required. The first step after release uses the reset configuration unless ld is applied.
- **Accumulator wrap** is mod 2^W. The carry is the only overflow indication.

## Test plan
- **Zero fraction:** rst pulse, ld frac=0 n=31 order=3, dith_en=0, en=1 → div_out=31 constant, sat=0, qn=0.
- **Half fraction, order 1:** W=16, ld frac=32768 n=31 order=1 → div_out alternates 31,32 with period 2; qn alternates 32768,0.
- **Mean accuracy:** frac=26625 n=31 order=3, 65536 enabled cycles →
  - sum(div_out-31) within 26625±3;
  - every y in -3..4;
  - the order-2 run stays within -1..2.
- **Clamp:** n=1 order=3 frac=26625 → div_out never below 0; sat=1 exactly on cycles where 1+y<0; no wrap to large values.
- **Order change and hold:**
  - Mid-run ld order 3→2 → busy=1 for one cycle; acc1..3=0 on the next cycle; div_out=n on that edge.
  - en=0 for 10 cycles → outputs and qn frozen.
  - ld during en=0 → takes effect on the first enabled step.
- **Reset and dither:**
  - Async rst asserted between edges → outputs go 0 without a clock edge.
  - dith_en=1, frac=0 → div_out varies; the LFSR sequence matches the reference model from SEED.
